// File: rtl/regfile_mp_bypass_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_bypass_if
// Description : Bus bundle for the multi-port register file. It carries the
//               two retire write lanes, the decode-side allocate request,
//               the packed read address/data ports, the per-port busy flags
//               and the registered lane-conflict flag.
//               master : decode/writeback side (drives writes, allocs, reads)
//               slave  : register file (returns read data, busy, conflict)
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_mp_bypass_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                       wr0_en;
    logic [ADDR_W-1:0]          wr0_addr;
    logic [DATA_W-1:0]          wr0_data;
    logic                       wr1_en;
    logic [ADDR_W-1:0]          wr1_addr;
    logic [DATA_W-1:0]          wr1_data;
    logic                       alloc_en;
    logic [ADDR_W-1:0]          alloc_addr;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic [NUM_RD-1:0]          rd_busy;
    logic                       wr_conflict;

    modport master (
        output wr0_en, wr0_addr, wr0_data,
        output wr1_en, wr1_addr, wr1_data,
        output alloc_en, alloc_addr,
        output rd_addr,
        input  rd_data, rd_busy, wr_conflict
    );

    modport slave (
        input  wr0_en, wr0_addr, wr0_data,
        input  wr1_en, wr1_addr, wr1_data,
        input  alloc_en, alloc_addr,
        input  rd_addr,
        output rd_data, rd_busy, wr_conflict
    );
endinterface
`default_nettype wire

// File: rtl/regfile_mp_bypass.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_bypass
// Description : Multi-port register file with two prioritised write lanes
//               (lane 1 wins on a same-register collision), NUM_RD
//               combinational read ports with optional write-to-read
//               forwarding, and a one-bit-per-register pending scoreboard
//               for RAW hazard detection. Register 0 is hard-wired to zero.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-low reset
//               bus   - regfile_mp_bypass_if.slave (write lanes, allocate,
//                       read ports, busy flags, wr_conflict)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp_bypass #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter int                NUM_RD   = 2,
    parameter int                BYPASS   = 1,
    parameter int                SP_INDEX = 29,
    parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_0080
) (
    input  wire logic            clk,
    input  wire logic            reset,
    regfile_mp_bypass_if.slave   bus
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [0:c_DEPTH-1];
    logic [c_DEPTH-1:0] r_pending;
    logic               r_wr_conflict;

    logic               w_wr0_ok;
    logic               w_wr1_ok;
    logic               w_same_addr;
    logic [c_DEPTH-1:0] w_pending_next;

    logic [DATA_W-1:0]  w_port_data [NUM_RD];
    logic               w_port_busy [NUM_RD];

    // A lane only ever does anything when it targets a non-zero register.
    assign w_wr0_ok    = bus.wr0_en && (bus.wr0_addr != '0);
    assign w_wr1_ok    = bus.wr1_en && (bus.wr1_addr != '0);
    assign w_same_addr = (bus.wr0_addr == bus.wr1_addr);

    // Scoreboard next state: retiring writes clear, a new allocation sets.
    // The set is applied last so a producer issued in the same cycle as a
    // retire to the same register keeps the register pending.
    always_comb begin
        w_pending_next = r_pending;
        if (w_wr0_ok) begin
            w_pending_next[bus.wr0_addr] = 1'b0;
        end
        if (w_wr1_ok) begin
            w_pending_next[bus.wr1_addr] = 1'b0;
        end
        if (bus.alloc_en && (bus.alloc_addr != '0)) begin
            w_pending_next[bus.alloc_addr] = 1'b1;
        end
        w_pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
            end
            r_pending     <= '0;
            r_wr_conflict <= 1'b0;
        end else begin
            // Lane 0 is dropped when the younger lane 1 hits the same register.
            if (w_wr0_ok && !(w_wr1_ok && w_same_addr)) begin
                r_regs[bus.wr0_addr] <= bus.wr0_data;
            end
            if (w_wr1_ok) begin
                r_regs[bus.wr1_addr] <= bus.wr1_data;
            end
            r_pending     <= w_pending_next;
            r_wr_conflict <= bus.wr0_en && bus.wr1_en && w_same_addr
                             && (bus.wr0_addr != '0);
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_stored;

        assign w_addr   = bus.rd_addr[k*ADDR_W +: ADDR_W];
        assign w_stored = (w_addr == '0) ? '0 : r_regs[w_addr];

        if (BYPASS != 0) begin : g_byp
            logic w_hit0;
            logic w_hit1;
            logic w_alloc_hit;

            assign w_hit0      = w_wr0_ok && (bus.wr0_addr == w_addr);
            assign w_hit1      = w_wr1_ok && (bus.wr1_addr == w_addr);
            assign w_alloc_hit = bus.alloc_en && (bus.alloc_addr == w_addr);

            assign w_port_data[k] = w_hit1 ? bus.wr1_data :
                                    w_hit0 ? bus.wr0_data : w_stored;
            // A forwarded value is ready now, so the hazard is hidden unless
            // a fresh producer is claiming the same register this cycle.
            assign w_port_busy[k] = r_pending[w_addr]
                                    && !((w_hit0 || w_hit1) && !w_alloc_hit);
        end else begin : g_nobyp
            assign w_port_data[k] = w_stored;
            assign w_port_busy[k] = r_pending[w_addr];
        end
    end

    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            bus.rd_data[k*DATA_W +: DATA_W] = w_port_data[k];
            bus.rd_busy[k]                  = w_port_busy[k];
        end
    end

    assign bus.wr_conflict = r_wr_conflict;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_bypass.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp_bypass
// Description : Self-checking bench. Two register files share the same write
//               and allocate stimulus: dut_a (4 read ports, forwarding on) and
//               dut_b (2 read ports, forwarding off). Directed scenarios are
//               followed by random traffic, all compared against a plain
//               array/bit-vector reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp_bypass;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr0_en, wr1_en, alloc_en;
    logic [AW-1:0] wr0_addr, wr1_addr, alloc_addr;
    logic [DW-1:0] wr0_data, wr1_data;
    logic [AW-1:0] ra [4];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_mp_bypass_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4)) bus_a ();
    regfile_mp_bypass_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2)) bus_b ();

    assign bus_a.wr0_en     = wr0_en;
    assign bus_a.wr0_addr   = wr0_addr;
    assign bus_a.wr0_data   = wr0_data;
    assign bus_a.wr1_en     = wr1_en;
    assign bus_a.wr1_addr   = wr1_addr;
    assign bus_a.wr1_data   = wr1_data;
    assign bus_a.alloc_en   = alloc_en;
    assign bus_a.alloc_addr = alloc_addr;
    assign bus_a.rd_addr    = {ra[3], ra[2], ra[1], ra[0]};

    assign bus_b.wr0_en     = wr0_en;
    assign bus_b.wr0_addr   = wr0_addr;
    assign bus_b.wr0_data   = wr0_data;
    assign bus_b.wr1_en     = wr1_en;
    assign bus_b.wr1_addr   = wr1_addr;
    assign bus_b.wr1_data   = wr1_data;
    assign bus_b.alloc_en   = alloc_en;
    assign bus_b.alloc_addr = alloc_addr;
    assign bus_b.rd_addr    = {ra[1], ra[0]};

    regfile_mp_bypass #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4), .BYPASS(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    regfile_mp_bypass #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .BYPASS(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [DW-1:0] m_mem [32];
    logic [31:0]   m_pend;
    logic          m_conf;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_mem[29] = 32'h0000_0080;
        m_pend    = '0;
        m_conf    = 1'b0;
    endtask

    task automatic model_edge();
        // Lane 1 is younger: applying it last gives it the final word.
        if (wr0_en && wr0_addr != 0) begin
            m_mem[wr0_addr]  = wr0_data;
            m_pend[wr0_addr] = 1'b0;
        end
        if (wr1_en && wr1_addr != 0) begin
            m_mem[wr1_addr]  = wr1_data;
            m_pend[wr1_addr] = 1'b0;
        end
        if (alloc_en && alloc_addr != 0) m_pend[alloc_addr] = 1'b1;
        m_conf = wr0_en && wr1_en && (wr0_addr == wr1_addr) && (wr0_addr != 0);
    endtask

    function automatic logic [DW-1:0] exp_rd(logic [AW-1:0] a, bit byp);
        logic [DW-1:0] v;
        if (a == 0) return '0;
        v = m_mem[a];
        if (byp && wr0_en && wr0_addr == a) v = wr0_data;
        if (byp && wr1_en && wr1_addr == a) v = wr1_data;
        return v;
    endfunction

    function automatic logic exp_busy(logic [AW-1:0] a, bit byp);
        bit written;
        if (a == 0) return 1'b0;
        written = (wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a);
        if (byp && written && !(alloc_en && alloc_addr == a)) return 1'b0;
        return m_pend[a];
    endfunction

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_ports();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("a_rd%0d", k), bus_a.rd_data[k*DW +: DW], exp_rd(ra[k], 1'b1));
            check($sformatf("a_busy%0d", k), bus_a.rd_busy[k], exp_busy(ra[k], 1'b1));
        end
        for (int k = 0; k < 2; k++) begin
            check($sformatf("b_rd%0d", k), bus_b.rd_data[k*DW +: DW], exp_rd(ra[k], 1'b0));
            check($sformatf("b_busy%0d", k), bus_b.rd_busy[k], exp_busy(ra[k], 1'b0));
        end
    endtask

    // Entered at a falling edge with inputs already driven.
    task automatic step();
        #1;
        check_ports();
        @(posedge clk);
        model_edge();
        #1;
        check("a_conf", bus_a.wr_conflict, m_conf);
        check("b_conf", bus_b.wr_conflict, m_conf);
        @(negedge clk);
    endtask

    task automatic idle();
        wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
        alloc_en = 1'b0; alloc_addr = '0;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 4) == 0) return AW'(29);
        return AW'($urandom_range(0, 7));
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        idle();
        for (int k = 0; k < 4; k++) ra[k] = '0;

        // Reset values
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        ra[0] = 29; ra[1] = 0; ra[2] = 5; ra[3] = 0;
        #1;
        check("rst_sp", bus_a.rd_data[31:0], 32'h80);
        check("rst_r5", bus_a.rd_data[95:64], 32'h0);
        check("rst_busy", bus_a.rd_busy, 4'h0);
        check("rst_conf", bus_a.wr_conflict, 1'b0);
        check_ports();
        @(negedge clk);
        reset = 1'b1;
        step();

        // Write with same-cycle forwarding
        wr0_en = 1'b1; wr0_addr = 5; wr0_data = 32'hDEAD_BEEF; ra[0] = 5;
        #1;
        check("byp_same", bus_a.rd_data[31:0], 32'hDEAD_BEEF);
        check("nobyp_same", bus_b.rd_data[31:0], 32'h0);
        step();
        idle();
        #1;
        check("byp_next", bus_a.rd_data[31:0], 32'hDEAD_BEEF);
        check("nobyp_next", bus_b.rd_data[31:0], 32'hDEAD_BEEF);
        step();

        // Lane collision
        wr0_en = 1'b1; wr0_addr = 7; wr0_data = 1;
        wr1_en = 1'b1; wr1_addr = 7; wr1_data = 2;
        ra[1] = 7;
        step();
        idle();
        #1;
        check("coll_conf1", bus_a.wr_conflict, 1'b1);
        check("coll_r7", bus_b.rd_data[63:32], 32'h2);
        step();
        check("coll_conf0", bus_a.wr_conflict, 1'b0);
        wr0_en = 1'b1; wr0_addr = 0; wr0_data = 3;
        wr1_en = 1'b1; wr1_addr = 0; wr1_data = 3;
        ra[2] = 0;
        step();
        idle();
        #1;
        check("r0_conf", bus_a.wr_conflict, 1'b0);
        check("r0_rd", bus_a.rd_data[95:64], 32'h0);
        step();

        // Scoreboard
        alloc_en = 1'b1; alloc_addr = 9; ra[3] = 9; ra[0] = 9;
        step();
        idle();
        #1;
        check("sb_alloc", bus_a.rd_busy[3], 1'b1);
        wr0_en = 1'b1; wr0_addr = 9; wr0_data = 32'h1234;
        #1;
        check("sb_fwd_hide", bus_a.rd_busy[3], 1'b0);
        check("sb_nofwd", bus_b.rd_busy[0], 1'b1);
        step();
        idle();
        #1;
        check("sb_clear", bus_a.rd_busy[3], 1'b0);
        wr1_en = 1'b1; wr1_addr = 9; wr1_data = 32'h5678;
        alloc_en = 1'b1; alloc_addr = 9;
        step();
        idle();
        #1;
        check("sb_wr_alloc", bus_a.rd_busy[3], 1'b1);
        alloc_en = 1'b1; alloc_addr = 0; ra[3] = 0;
        step();
        idle();
        #1;
        check("sb_r0", bus_a.rd_busy[3], 1'b0);
        step();

        // Mid-operation asynchronous reset
        alloc_en = 1'b1; alloc_addr = 3;
        wr0_en = 1'b1; wr0_addr = 29; wr0_data = 5;
        ra[0] = 29; ra[1] = 3;
        step();
        idle();
        #2;
        wr0_en = 1'b1; wr0_addr = 29; wr0_data = 5;
        alloc_en = 1'b1; alloc_addr = 3;
        reset = 1'b0;
        model_reset();
        #1;
        idle();
        #1;
        check("mrst_sp", bus_a.rd_data[31:0], 32'h80);
        check("mrst_busy", bus_b.rd_busy[1], 1'b0);
        check_ports();
        wr0_en = 1'b1; wr0_addr = 29; wr0_data = 5;
        alloc_en = 1'b1; alloc_addr = 3;
        @(posedge clk);
        #1;
        idle();
        #1;
        check("mrst_nowr", bus_b.rd_data[31:0], 32'h80);
        check("mrst_nopend", bus_a.rd_busy[1], 1'b0);
        check_ports();
        @(negedge clk);
        reset = 1'b1;
        step();

        // Four independent read ports
        wr0_en = 1'b1; wr0_addr = 1; wr0_data = 11;
        wr1_en = 1'b1; wr1_addr = 2; wr1_data = 22;
        step();
        wr0_addr = 3; wr0_data = 33;
        wr1_addr = 4; wr1_data = 44;
        step();
        idle();
        for (int k = 0; k < 4; k++) ra[k] = AW'(k + 1);
        #1;
        check("p0", bus_a.rd_data[31:0], 32'd11);
        check("p1", bus_a.rd_data[63:32], 32'd22);
        check("p2", bus_a.rd_data[95:64], 32'd33);
        check("p3", bus_a.rd_data[127:96], 32'd44);
        step();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            wr0_en     = 1'($urandom_range(0, 1));
            wr0_addr   = rnd_addr();
            wr0_data   = $urandom;
            wr1_en     = 1'($urandom_range(0, 1));
            wr1_addr   = rnd_addr();
            wr1_data   = $urandom;
            alloc_en   = 1'($urandom_range(0, 1));
            alloc_addr = rnd_addr();
            for (int k = 0; k < 4; k++) ra[k] = rnd_addr();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
